// File: rtl/bus_writeback_bank_if.sv
// Bus-side signals of the write-back register bank: capture data, one-hot
// write strobes, error clear, flat register read bus and commit status.
interface bus_writeback_bank_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]    bus_in;
    logic [31:0]         rin;
    logic                err_clr;
    logic [32*WIDTH-1:0] q_flat;
    logic                wr_valid;
    logic [4:0]          wr_idx;
    logic                err_multi;
    logic [7:0]          wr_count;

    modport master (
        output bus_in, rin, err_clr,
        input  q_flat, wr_valid, wr_idx, err_multi, wr_count
    );

    modport slave (
        input  bus_in, rin, err_clr,
        output q_flat, wr_valid, wr_idx, err_multi, wr_count
    );
endinterface

// File: rtl/bus_writeback_bank.sv
// Write-side register bank: captures the shared bus into the register picked by a
// one-hot strobe. Optional macro R0_HARDWIRED_ZERO_EN makes register 0 a constant zero.
module bus_writeback_bank #(
    parameter int               WIDTH    = 32,
    parameter int               NUM_REGS = 24,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input logic                 clk,
    input logic                 clear,
    bus_writeback_bank_if.slave bus
);

`ifdef R0_HARDWIRED_ZERO_EN
    localparam int FIRST_REG = 1;
`else
    localparam int FIRST_REG = 0;
`endif

    localparam logic [31:0] IMPL_MASK =
        (NUM_REGS >= 32) ? '1 : ((32'd1 << NUM_REGS) - 32'd1);

    logic [WIDTH-1:0] reg_q [FIRST_REG:NUM_REGS-1];
    logic [WIDTH-1:0] reg_d [FIRST_REG:NUM_REGS-1];

    logic       wr_valid_q, wr_valid_d;
    logic [4:0] wr_idx_q, wr_idx_d;
    logic       err_multi_q, err_multi_d;
    logic [7:0] wr_count_q, wr_count_d;

    logic [4:0] hot_idx;
    logic       legal;
    logic       illegal;

    // Legal only when exactly one strobe is set and it names an implemented register.
    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (bus.rin[i]) begin
                hot_idx = 5'(i);
            end
        end
        legal   = $onehot(bus.rin) && ((bus.rin & ~IMPL_MASK) == '0);
        illegal = (bus.rin != '0) && !legal;
    end

    always_comb begin
        for (int i = FIRST_REG; i < NUM_REGS; i++) begin
            reg_d[i] = (legal && bus.rin[i]) ? bus.bus_in : reg_q[i];
        end
    end

    always_comb begin
        wr_valid_d  = legal;
        wr_idx_d    = legal ? hot_idx : wr_idx_q;
        wr_count_d  = (legal && (wr_count_q != 8'hFF)) ? wr_count_q + 8'd1 : wr_count_q;
        err_multi_d = err_multi_q;
        if (illegal) begin
            err_multi_d = 1'b1;
        end else if (bus.err_clr) begin
            err_multi_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int i = FIRST_REG; i < NUM_REGS; i++) begin
                reg_q[i] <= RST_VAL;
            end
            wr_valid_q  <= 1'b0;
            wr_idx_q    <= '0;
            err_multi_q <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            for (int i = FIRST_REG; i < NUM_REGS; i++) begin
                reg_q[i] <= reg_d[i];
            end
            wr_valid_q  <= wr_valid_d;
            wr_idx_q    <= wr_idx_d;
            err_multi_q <= err_multi_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Unimplemented slices, and register 0 when hardwired, read as zero.
    always_comb begin
        bus.q_flat = '0;
        for (int i = FIRST_REG; i < NUM_REGS; i++) begin
            bus.q_flat[i*WIDTH +: WIDTH] = reg_q[i];
        end
    end

    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_idx    = wr_idx_q;
    assign bus.err_multi = err_multi_q;
    assign bus.wr_count  = wr_count_q;

endmodule
